// File: rtl/setting_seq.sv
// rtl/setting_seq.sv - wash-programme setting block with run sequencing (optional SETTING_SEQ_KEEP_EN)
// Holds phase mask and water level, sequences phases from timer advances, reports time units.
`ifndef TG_WAS
`define TG_WAS 4'd3
`endif
`ifndef TG_RIN
`define TG_RIN 4'd1
`endif
`ifndef TG_DRY
`define TG_DRY 4'd2
`endif

module setting_seq #(
  parameter int NPH = 3,
  parameter int TG_W = 4,
  parameter logic [NPH*TG_W-1:0] TGS = {`TG_DRY, `TG_RIN, `TG_WAS},
  parameter int WAT_MIN = 2,
  parameter int WAT_MAX = 5,
  parameter int WAT_DEF = 3,
  parameter int UW = 6,
  localparam int CW = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           tr_mod,
  input  logic           tr_wat,
  input  logic           tr_run,
  input  logic           tr_adv,
  output logic [NPH-1:0] mode,
  output logic [NPH-1:0] ld_ph,
  output logic [CW-1:0]  cur_ph,
  output logic [UW-1:0]  u_wat,
  output logic [UW-1:0]  u_tot,
  output logic [UW-1:0]  u_cur,
  output logic [UW-1:0]  u_rem,
  output logic           running,
  output logic           paused,
  output logic           done
);

  localparam int SW = TG_W + $clog2(NPH + 1);
  localparam int PW = UW + SW;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state, state_nxt;
  logic [NPH-1:0] rem, rem_nxt;
  logic [NPH-1:0] mode_nxt;
  logic [UW-1:0]  wat, wat_nxt;
`ifdef SETTING_SEQ_KEEP_EN
  logic [NPH-1:0] shadow, shadow_nxt;
`endif

  // Strict priority: only the highest pending key pulse is acted on.
  logic ev_run, ev_adv, ev_mod, ev_wat;
  assign ev_run = tr_run;
  assign ev_adv = tr_adv & ~tr_run;
  assign ev_mod = tr_mod & ~tr_adv & ~tr_run;
  assign ev_wat = tr_wat & ~tr_mod & ~tr_adv & ~tr_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      mode   <= '1;
      wat    <= UW'(WAT_DEF);
`ifdef SETTING_SEQ_KEEP_EN
      shadow <= '1;
`endif
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      mode   <= mode_nxt;
      wat    <= wat_nxt;
`ifdef SETTING_SEQ_KEEP_EN
      shadow <= shadow_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    mode_nxt  = mode;
    wat_nxt   = wat;
`ifdef SETTING_SEQ_KEEP_EN
    shadow_nxt = shadow;
`endif
    if (clr) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
`ifdef SETTING_SEQ_KEEP_EN
      mode_nxt  = shadow;
`else
      mode_nxt  = '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ev_run) begin
            rem_nxt   = mode;
            state_nxt = RUN;
`ifdef SETTING_SEQ_KEEP_EN
            shadow_nxt = mode;
`endif
          end else if (ev_mod) begin
            mode_nxt = (mode == NPH'(1)) ? '1 : mode - NPH'(1);
          end else if (ev_wat) begin
            wat_nxt = (wat >= UW'(WAT_MAX)) ? UW'(WAT_MIN) : wat + UW'(1);
          end
        end
        RUN: begin
          if (ev_run) begin
            state_nxt = PAUSE;
          end else if (ev_adv) begin
            // Clearing the lowest set bit retires the phase that just finished.
            rem_nxt = rem & (rem - NPH'(1));
            if (rem_nxt == '0) state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (ev_run) state_nxt = RUN;
        end
        DONE: begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ld_ph   = (state == IDLE) ? mode : rem;
  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign done    = (state == DONE);
  assign u_wat   = wat;

  logic [SW-1:0]   sum_tot, sum_rem;
  logic [TG_W-1:0] base_cur;
  logic [CW-1:0]   cur_idx;
  logic            found;

  always_comb begin
    sum_tot  = '0;
    sum_rem  = '0;
    base_cur = '0;
    cur_idx  = '0;
    found    = 1'b0;
    for (int i = 0; i < NPH; i++) begin
      if (mode[i]) sum_tot = sum_tot + SW'(TGS[i*TG_W +: TG_W]);
      if (rem[i])  sum_rem = sum_rem + SW'(TGS[i*TG_W +: TG_W]);
      if (ld_ph[i] && !found) begin
        found    = 1'b1;
        cur_idx  = CW'(i);
        base_cur = TGS[i*TG_W +: TG_W];
      end
    end
  end

  function automatic logic [UW-1:0] sat(input logic [PW-1:0] p);
    return (|p[PW-1:UW]) ? '1 : p[UW-1:0];
  endfunction

  logic [PW-1:0] p_tot, p_cur, p_rem;
  assign p_tot = PW'(wat) * PW'(sum_tot);
  assign p_cur = PW'(wat) * PW'(base_cur);
  assign p_rem = PW'(wat) * PW'(sum_rem);

  assign cur_ph = cur_idx;
  assign u_tot  = sat(p_tot);
  assign u_cur  = sat(p_cur);
  assign u_rem  = sat(p_rem);

endmodule

// File: tb/tb_setting_seq.sv
// tb/tb_setting_seq.sv - vector table plus scoreboard bench for setting_seq
module tb_setting_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, tr_mod = 1'b0, tr_wat = 1'b0, tr_run = 1'b0, tr_adv = 1'b0;

  logic [2:0] mode, ld_ph;
  logic [1:0] cur_ph;
  logic [5:0] u_wat, u_tot, u_cur, u_rem;
  logic       running, paused, done;

  logic [2:0] mode2, ld_ph2;
  logic [1:0] cur_ph2;
  logic [3:0] u_wat2, u_tot2, u_cur2, u_rem2;
  logic       running2, paused2, done2;

  always #5 clk = ~clk;

  setting_seq dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tr_mod(tr_mod), .tr_wat(tr_wat),
    .tr_run(tr_run), .tr_adv(tr_adv), .mode(mode), .ld_ph(ld_ph), .cur_ph(cur_ph),
    .u_wat(u_wat), .u_tot(u_tot), .u_cur(u_cur), .u_rem(u_rem),
    .running(running), .paused(paused), .done(done)
  );

  // Narrow outputs so the default programme overflows and saturates.
  setting_seq #(.UW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tr_mod(tr_mod), .tr_wat(tr_wat),
    .tr_run(tr_run), .tr_adv(tr_adv), .mode(mode2), .ld_ph(ld_ph2), .cur_ph(cur_ph2),
    .u_wat(u_wat2), .u_tot(u_tot2), .u_cur(u_cur2), .u_rem(u_rem2),
    .running(running2), .paused(paused2), .done(done2)
  );

  typedef struct {
    logic [4:0] in;   // {clr, run, adv, mod, wat}
    logic [2:0] m, ld;
    logic [1:0] cur;
    int         w, tot, uc, ur;
    logic [2:0] fl;   // {running, paused, done}
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] C = 5'b10000, R = 5'b01000, A = 5'b00100, M = 5'b00010, W = 5'b00001, N = 5'b00000;
`ifdef SETTING_SEQ_KEEP_EN
  localparam int KM = 3, KT = 12, KT4 = 16;
`else
  localparam int KM = 7, KT = 18, KT4 = 24;
`endif

  task automatic add(input logic [4:0] in, input int m, ld, cur, w, tot, uc, ur, fl);
    vec_t v;
    v.in = in; v.m = 3'(m); v.ld = 3'(ld); v.cur = 2'(cur);
    v.w = w; v.tot = tot; v.uc = uc; v.ur = ur; v.fl = 3'(fl);
    tbl.push_back(v);
  endtask

  function automatic logic [3:0] sat4(input int x);
    return (x > 15) ? 4'hf : 4'(x);
  endfunction

  task automatic check(input string name);
    vec_t e;
    logic [34:0] act, expv;
    logic [15:0] act2, exp2;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    act  = {mode, ld_ph, cur_ph, u_wat, u_tot, u_cur, u_rem, running, paused, done};
    expv = {e.m, e.ld, e.cur, 6'(e.w), 6'(e.tot), 6'(e.uc), 6'(e.ur), e.fl};
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (mode ld cur wat tot cur rem flags)", name, act, expv);
    end
    act2 = {u_wat2, u_tot2, u_cur2, u_rem2};
    exp2 = {4'(e.w), sat4(e.tot), sat4(e.uc), sat4(e.ur)};
    n_cmp++;
    if (act2 !== exp2) begin
      n_bad++;
      $display("FAIL %s_sat: got %h want %h (wat tot cur rem)", name, act2, exp2);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    {clr, tr_run, tr_adv, tr_mod, tr_wat} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    {clr, tr_run, tr_adv, tr_mod, tr_wat} = 5'b0;
    check($sformatf("vec%0d", idx));
  endtask

  vec_t rst_v;

  initial begin
    add(M,     6,6,1,3, 9, 3, 0,0);
    add(M,     5,5,0,3,15, 9, 0,0);
    add(M,     4,4,2,3, 6, 6, 0,0);
    add(M,     3,3,0,3,12, 9, 0,0);
    add(M,     2,2,1,3, 3, 3, 0,0);
    add(M,     1,1,0,3, 9, 9, 0,0);
    add(M,     7,7,0,3,18, 9, 0,0);
    add(W,     7,7,0,4,24,12, 0,0);
    add(W,     7,7,0,5,30,15, 0,0);
    add(W,     7,7,0,2,12, 6, 0,0);
    add(W,     7,7,0,3,18, 9, 0,0);
    add(M|W,   6,6,1,3, 9, 3, 0,0);
    add(C,     7,7,0,3,18, 9, 0,0);
    add(R,     7,7,0,3,18, 9,18,4);
    add(A,     7,6,1,3,18, 3, 9,4);
    add(R,     7,6,1,3,18, 3, 9,2);
    add(A,     7,6,1,3,18, 3, 9,2);
    add(M,     7,6,1,3,18, 3, 9,2);
    add(W,     7,6,1,3,18, 3, 9,2);
    add(R,     7,6,1,3,18, 3, 9,4);
    add(A,     7,4,2,3,18, 6, 6,4);
    add(A,     7,0,0,3,18, 0, 0,1);
    add(N,     7,7,0,3,18, 9, 0,0);
    add(R|A,   7,7,0,3,18, 9,18,4);
    add(C,     7,7,0,3,18, 9, 0,0);
    add(N,     7,7,0,3,18, 9, 0,0);
    add(M,     6,6,1,3, 9, 3, 0,0);
    add(M,     5,5,0,3,15, 9, 0,0);
    add(M,     4,4,2,3, 6, 6, 0,0);
    add(M,     3,3,0,3,12, 9, 0,0);
    add(R,     3,3,0,3,12, 9,12,4);
    add(C,     KM,KM,0,3,KT, 9, 0,0);
    add(W,     KM,KM,0,4,KT4,12, 0,0);
    add(R,     KM,KM,0,4,KT4,12,KT4,4);

    rst_v.in = N; rst_v.m = 3'd7; rst_v.ld = 3'd7; rst_v.cur = 2'd0;
    rst_v.w = 3; rst_v.tot = 18; rst_v.uc = 9; rst_v.ur = 0; rst_v.fl = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(rst_v);
    check("reset");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i + 1);

    // Asynchronous reset while running, observed before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(rst_v);
    check("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(rst_v);
    check("reset_held");
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
